// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a requester and the PS/2 host transmitter.
// Latency: none, this is wiring only.
// Backpressure: tx_ready gates acceptance; tx_done/tx_err report the outcome.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ack check.
// Latency: pad clock fall to data enable change is 3 cycles; all outputs registered.
// Backpressure: one byte in flight; tx_valid is ignored while tx_ready is low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic           app_clk,
    input  logic           app_arst_n,
    ps2_host_tx_if.slave   tx_if,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);

    // One counter serves both the inhibit hold and the device timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [3:0]         idx, idx_d;
    logic [7:0]         data_q, data_d;
    logic               par_q, par_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               clk_s1, clk_s2, clk_s3;
    logic               dat_s1, dat_s2;
    logic               clk_fall;
    logic               frame_bit;
    logic               to_hit;
    logic [CNT_W-1:0]   cnt_inc;

    // Synchronize both pads; reset to the idle-high level so no false edge appears.
    always_ff @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data_in;
            dat_s2 <= dat_s1;
        end
    end

    assign clk_fall = clk_s3 & ~clk_s2;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign to_hit   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Select the frame bit for the current index: data LSB first, parity, then stop.
    always_comb begin
        frame_bit = 1'b1;
        if (idx < 4'd8) begin
            frame_bit = data_q[idx[2:0]];
        end else if (idx == 4'd8) begin
            frame_bit = par_q;
        end
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = idx;
        data_d    = data_q;
        par_d     = par_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                if (tx_if.tx_valid && ready_q) begin
                    data_d   = tx_if.tx_data;
                    par_d    = ~^tx_if.tx_data;
                    cnt_d    = '0;
                    state_d  = S_INHIBIT;
                    ready_d  = 1'b0;
                    clk_oe_d = 1'b1;
                end
            end

            S_INHIBIT: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                cnt_d     = cnt_inc;
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    // Start bit overlaps the last clock-low cycle by one cycle.
                    state_d   = S_REQ;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                end
            end

            S_REQ: begin
                state_d   = S_SHIFT;
                idx_d     = '0;
                cnt_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
            end

            S_SHIFT: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_bit;
                    idx_d     = idx + 4'd1;
                    cnt_d     = '0;
                    if (idx == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (to_hit) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_ACK: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (!dat_s2) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        data_oe_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (to_hit) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (to_hit) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset releases both lines with no pulse.
    always_ff @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            data_q    <= data_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_if.tx_ready = ready_q;
    assign tx_if.tx_done  = done_q;
    assign tx_if.tx_err   = err_q;
    assign ps2_clk_oe     = clk_oe_q;
    assign ps2_data_oe    = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the Mercury baseboard: it sends command bytes to a PS/2 keyboard or mouse, such as set-LEDs (0xED) or reset (0xFF). It is the outbound counterpart of the PS/2 receive path on `PS2_CLK`/`PS2_DATA`. It drives both lines open-drain through output enables, and the top level ties each pad low when its enable is high. It runs in the 25 MHz domain (`app_clk25` / `app_arst25_n`) beside `vga_sync`.

## Interface

**Parameters**
- `INHIBIT_CYCLES`, default 2500: cycles the host holds PS/2 clock low to request to send (100 µs at 25 MHz).
- `TIMEOUT_CYCLES`, default 375000: maximum cycles between device clock falling edges, and for line-idle wait (15 ms at 25 MHz).

**Ports**
- `app_clk` input 1: system clock; all logic is on the rising edge.
- `app_arst_n` input 1: asynchronous active-low reset.
- `tx_data` input 8: byte to send; sampled on accept.
- `tx_valid` input 1: request to send `tx_data`.
- `tx_ready` output 1: block idle; a transfer is accepted when `tx_valid & tx_ready`.
- `tx_done` output 1: one-cycle pulse; byte sent and device acknowledged.
- `tx_err` output 1: one-cycle pulse; timeout, or no acknowledge from the device.
- `ps2_clk_in` input 1: raw PS/2 clock pad level (asynchronous).
- `ps2_data_in` input 1: raw PS/2 data pad level (asynchronous).
- `ps2_clk_oe` output 1: 1 = pull PS/2 clock low; 0 = release.
- `ps2_data_oe` output 1: 1 = pull PS/2 data low; 0 = release.

## Operation

**Input conditioning**
- `ps2_clk_in` and `ps2_data_in` each pass through a 2-flop synchronizer.
- A third flop on the synchronized clock gives a falling-edge strobe `clk_fall`.

**Frame**
- Each byte is sent as: start bit (0), d0 to d7 LSB first, odd parity (`~^tx_data`), stop bit (1).
- The device then returns an ack bit (0).
- Drive rule: `ps2_data_oe = ~bit`, so a 0 bit pulls the line low and a 1 bit releases it.

**FSM states**
- **IDLE**
  - `tx_ready`=1; both output enables 0.
  - On accept: latch `tx_data` and its parity, clear the counter, go to INHIBIT.
- **INHIBIT**
  - `ps2_clk_oe`=1, `ps2_data_oe`=0 for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
- **REQ** (one cycle)
  - `ps2_clk_oe`=1 and `ps2_data_oe`=1, which drives the start bit.
  - Then go to SHIFT with bit index 0 and the timeout counter cleared.
- **SHIFT**
  - `ps2_clk_oe`=0.
  - On each `clk_fall`, drive frame bit `idx`, increment `idx`, and clear the timeout counter:
    - idx 0 to 7: data bits
    - idx 8: parity
    - idx 9: stop bit (`ps2_data_oe`=0)
  - After the stop bit is driven, go to ACK.
- **ACK**
  - On the next `clk_fall`, sample the synchronized data line.
  - Data 0: go to WAIT_IDLE.
  - Data 1: pulse `tx_err` and go to IDLE.
- **WAIT_IDLE**
  - Wait until the synchronized clock and data lines are both 1.
  - Then pulse `tx_done` and go to IDLE.

**Timeout**
- Applies in SHIFT, ACK and WAIT_IDLE.
- The counter increments every cycle and clears on `clk_fall`.
- Reaching `TIMEOUT_CYCLES` releases both output enables, pulses `tx_err`, and goes to IDLE. This aborts the frame.

**Boundary rules**
- `tx_valid` while `tx_ready`=0 is ignored. There is no queuing, and the latched byte is unaffected.
- `tx_done` and `tx_err` are never asserted in the same cycle.
- A `clk_fall` in the same cycle the timeout counter reaches terminal count: the edge wins and the counter clears.
- Device clock edges during IDLE, INHIBIT or REQ are ignored.
- Reset asserted mid-frame: all outputs go to their reset values at once (lines released, FSM in IDLE). No `tx_err` pulse is produced.

## Timing

**Reset values**
- `tx_ready`=1.
- `tx_done`=0, `tx_err`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0.
- All outputs are registered.

**Accept to bus (accept in cycle 0)**
- `tx_ready`=0 from cycle 1.
- `ps2_clk_oe`=1 for cycles 1 to `INHIBIT_CYCLES`.
- `ps2_data_oe`=1 from cycle `INHIBIT_CYCLES`+1.
- `ps2_clk_oe`=0 from cycle `INHIBIT_CYCLES`+2.

**Pad to response**
- A pad falling edge on `ps2_clk_in` updates `ps2_data_oe` exactly 3 `app_clk` cycles later (2 sync flops + 1 register).
- Ack sampling happens with the same 3-cycle latency.

**Completion**
- `tx_done` or `tx_err` pulses exactly 1 cycle.
- The FSM is in IDLE in the pulse cycle, and `tx_ready` returns to 1 in the cycle after the pulse.
- A new `tx_valid` can be accepted in that cycle.

**Device-side limits**
- Max device clock rate is bounded by `app_clk`/8 (clock high and low phases must each be ≥4 `app_clk` cycles).
- Real PS/2 runs at 10 to 16.7 kHz, far below that bound.

## Test plan

- **Send 0xED with a BFM device model** (12 clock falls, ack 0, then lines released):
  - Check clock held low for 2500 cycles and 1 cycle of start-bit overlap.
  - Sampled bits on device rising edges must be 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `tx_done` pulses once; `tx_ready` returns to 1.
- **Parity coverage**: send 0x00, 0x01, 0xFF; device must sample parity 1, 0, 1 respectively.
- **No ack**: device leaves data high on the 11th fall → `tx_err` pulse, no `tx_done`, both output enables 0, `tx_ready`=1 next cycle.
- **Device silent**: no clock edges after REQ → `tx_err` exactly `TIMEOUT_CYCLES` cycles after REQ exits; lines released. Repeat with the device stopping after the 4th bit.
- **Busy and back-to-back**:
  - Assert `tx_valid` with 0x55 during INHIBIT of 0xAA → the device receives only 0xAA.
  - Holding `tx_valid` through `tx_done` gets 0x55 accepted in the cycle `tx_ready` returns to 1.
- **Reset mid-frame**:
  - Deassert `app_arst_n` at bit 5 → output enables 0, `tx_ready`=1 immediately, no `tx_done`/`tx_err`.
  - A subsequent 0xFF transfer completes normally.
